pipeline_elastic: RTL and testbench
===================================

// Module: pipeline_elastic
// PURPOSE
//  Parametrised successor to the fixed delay-line pipeline: a Depth-stage
//  register pipeline with per-stage valid bits and valid/ready flow control.
//  Bubbles collapse: a stage loads whenever it is empty or draining, so
//  back-pressure stalls only full stages.
//  Sits between a producer and a consumer that may stall. Used as a
//  timing-closure slice and skid-free retiming element in datapaths.
// PARAMETERS
//  Width  15  data bits per beat (>=1)
//  Depth  2   register stages (>=0); 0 = combinational passthrough
//  CntW   $clog2(Depth+1) (localparam)  width of occupancy
// PORTS
//  clk        in   1        sole clock, all logic on posedge
//  rst_n      in   1        synchronous reset, active-low
//  in_valid   in   1        producer beat valid
//  in_ready   out  1        pipeline can accept a beat this cycle
//  in_data    in   Width    producer data
//  out_valid  out  1        stage Depth-1 holds a beat
//  out_ready  in   1        consumer accepts the beat
//  out_data   out  Width    stage Depth-1 data
//  occupancy  out  CntW     number of valid stages (max(CntW,1) bits when Depth=0, reads 0)
//  flush      in   1        only with PIPELINE_ELASTIC_FLUSH_EN
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): all stage valids v[i]<=0, all data regs
//    <=0. Hence after reset: out_valid=0, out_data=0, occupancy=0,
//    in_ready=1. Reset mid-stream discards all in-flight beats with no
//    output transfer. A transfer offered in the reset cycle is ignored.
//  - Transfer rule: in-beat accepted iff in_valid&&in_ready at posedge.
//    Out-beat consumed iff out_valid&&out_ready at posedge.
//  - Stage advance (Depth>=1): adv[D-1]=v[D-1]&&out_ready;
//    adv[i]=v[i]&&(!v[i+1]||adv[i+1]). Stage i+1 loads from stage i when adv[i].
//    Stage 0 loads in_data when in_valid&&in_ready.
//  - in_ready = !v[0] || adv[0]. Ready path is combinational, back to
//    out_ready; data/valid paths are fully registered.
//  - Latency: an accepted beat reaches out_valid exactly Depth cycles
//    after acceptance if never stalled; throughput 1 beat/cycle when
//    out_ready held 1.
//  - Stall: a stage not advancing holds data and valid; data regs load
//    only on valid advance, so out_data is stable while out_valid&&!out_ready.
//  - Order preserved; no beat dropped or duplicated. Full = all v[i]=1;
//    in_ready=1 when full only if out_ready=1 (simultaneous push/pop).
//  - occupancy = popcount(v); changes by -1, 0 or +1 per cycle (+1 on
//    accept only, -1 on consume only, 0 on both or neither).
//  - Depth==0: out_valid=in_valid, out_data=in_data, in_ready=out_ready,
//    occupancy=0; no state; reset has no effect on outputs.
// CONFIGURATION
//  PIPELINE_ELASTIC_FLUSH_EN defined: adds input flush. flush=1 at posedge
//  clears all v[i] (data regs hold); in that cycle in_ready=0 and
//  out_valid=0 (combinationally masked), so no transfer either side.
//  rst_n=0 has priority over flush. Depth==0: flush masks in_ready and
//  out_valid, no state.
//  Undefined: no flush port; behaviour as above with flush treated as 0.
// TESTING
//  Directed scenarios; scoreboard every out-beat against a reference queue.
//  Each scenario runs at Depth in {0,1,2,5}.
//  1 Reset: rst_n=0 3 cycles, in_valid=1 -> out_valid=0, occupancy=0,
//    in_ready=1; no beat appears after release.
//  2 Streaming: out_ready=1, push 0x0001..0x0064 back-to-back -> first
//    out_valid at acceptance+Depth, 100 beats in order, no gap.
//  3 Back-pressure: Depth=2, push 0x0AAA,0x0BBB,0x0CCC, out_ready=0 ->
//    occupancy=2, in_ready=0, out_data=0x0AAA held stable; release ->
//    beats out in order.
//  4 Bubble collapse: Depth=5, one beat 0x1234 then idle, out_ready=0 ->
//    beat reaches stage 4 after 5 cycles; 4 more beats accepted before
//    in_ready=0.
//  5 Full simultaneous: full Depth=5, in_valid=out_ready=1 -> in_ready=1,
//    occupancy stays 5 for 20 cycles, data in order.
//  6 Mid-stream reset/flush: occupancy=3, pulse rst_n=0 1 cycle ->
//    occupancy=0 next cycle, no stale beat out; with
//    PIPELINE_ELASTIC_FLUSH_EN repeat using flush=1 -> same result,
//    in_ready=0 during flush.

Source files
------------

// File: rtl/pipeline_elastic.sv
// ---------------------------------------------------------------------------
// pipeline_elastic
//   Depth-stage register pipeline with one valid bit per stage and
//   valid/ready flow control. Bubbles collapse: a stage loads whenever it
//   is empty or its contents are moving on, so back-pressure stalls only
//   the full stages nearest the consumer. Depth=0 is a plain wire-through.
//
// Parameters
//   Width  data bits per beat (>=1)
//   Depth  register stages (>=0)
//   CntW   occupancy width, $clog2(Depth+1) (1 bit when Depth=0)
//
// Ports
//   clk        sole clock, all state on posedge
//   rst_n      synchronous reset, active-low
//   in_valid   producer beat valid
//   in_ready   pipeline can accept a beat this cycle
//   in_data    producer data
//   out_valid  last stage holds a beat
//   out_ready  consumer accepts the beat
//   out_data   last stage data
//   occupancy  number of valid stages (always 0 when Depth=0)
//   flush      present only when PIPELINE_ELASTIC_FLUSH_EN is defined:
//              clears every stage valid (data regs hold) and masks
//              in_ready/out_valid in that cycle
//
// Handshake: a beat moves on a side exactly when valid && ready are both
// high at the rising clock edge. valid never waits on ready; ready on the
// input side is combinational from out_ready, while data and valid leave
// the pipeline straight from registers.
// ---------------------------------------------------------------------------
module pipeline_elastic #(
  parameter int Width = 15,
  parameter int Depth = 2,
  localparam int CntW = (Depth == 0) ? 1 : $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef PIPELINE_ELASTIC_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data,
  output logic [CntW-1:0]  occupancy
);

  logic flush_i;
`ifdef PIPELINE_ELASTIC_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  if (Depth == 0) begin : g_pass
    // No state: clock and reset are intentionally unused here.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign out_valid = in_valid && !flush_i;
    assign in_ready  = out_ready && !flush_i;
    assign out_data  = in_data;
    assign occupancy = '0;
  end else begin : g_pipe
    logic [Depth-1:0] v;
    logic [Depth-1:0] adv;
    logic [Width-1:0] d [Depth];
    logic             accept;

    // adv[i]: stage i hands its beat downstream this cycle. Walk from the
    // consumer end; "room" says whether the next stage down can take a beat.
    always_comb begin
      logic room;
      logic a;
      adv  = '0;
      room = out_ready && !flush_i;
      a    = 1'b0;
      for (int i = Depth - 1; i >= 0; i--) begin
        a      = v[i] && room;
        adv[i] = a;
        room   = !v[i] || a;
      end
    end

    assign in_ready  = (!v[0] || adv[0]) && !flush_i;
    assign accept    = in_valid && in_ready;
    assign out_valid = v[Depth-1] && !flush_i;
    assign out_data  = d[Depth-1];

    always_comb begin
      occupancy = '0;
      for (int i = 0; i < Depth; i++) begin
        occupancy = occupancy + CntW'(v[i]);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v <= '0;
        for (int i = 0; i < Depth; i++) begin
          d[i] <= '0;
        end
      end else if (flush_i) begin
        // Drop every in-flight beat; data registers keep their contents.
        v <= '0;
      end else begin
        if (accept) begin
          d[0] <= in_data;
          v[0] <= 1'b1;
        end else if (adv[0]) begin
          v[0] <= 1'b0;
        end
        for (int i = 1; i < Depth; i++) begin
          if (adv[i-1]) begin
            d[i] <= d[i-1];
            v[i] <= 1'b1;
          end else if (adv[i]) begin
            v[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_elastic.sv
module tb_pipeline_elastic;
  localparam int W    = 15;
  localparam int NDUT = 4;
  localparam int DEPS [NDUT] = '{0, 1, 2, 5};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic [W-1:0] in_data   = '0;
  logic         out_ready = 1'b0;
  logic         flush     = 1'b0;
  int           cur       = 0;

  logic         iv_a  [NDUT];
  logic         ir_a  [NDUT];
  logic         ov_a  [NDUT];
  logic [W-1:0] od_a  [NDUT];
  logic [2:0]   occ_a [NDUT];

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    localparam int D  = DEPS[k];
    localparam int CW = (D == 0) ? 1 : $clog2(D + 1);
    logic [CW-1:0] occ;
    assign iv_a[k]  = in_valid && (cur == k);
    assign occ_a[k] = 3'(occ);
    pipeline_elastic #(.Width(W), .Depth(D)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef PIPELINE_ELASTIC_FLUSH_EN
      .flush     (flush),
`endif
      .in_valid  (iv_a[k]),
      .in_ready  (ir_a[k]),
      .in_data   (in_data),
      .out_valid (ov_a[k]),
      .out_ready (out_ready),
      .out_data  (od_a[k]),
      .occupancy (occ)
    );
  end

  logic         ir, ov;
  logic [W-1:0] od;
  logic [2:0]   occ;
  always_comb begin
    ir  = ir_a[cur];
    ov  = ov_a[cur];
    od  = od_a[cur];
    occ = occ_a[cur];
  end

  // ---------------- reference model / scoreboard ----------------
  // Each in-flight beat carries its stage position. A beat moves one stage
  // per cycle unless the beat ahead of it is still directly in front.
  logic [W-1:0] exp_q[$];
  int           pos_q[$];
  logic [W-1:0] last_od;   // value the last stage register should show
  int           dep;
  int           checks   = 0;
  int           failures = 0;
  logic         chk_en   = 1'b0;
  int           cyc, out_cnt, first_acc, first_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, cur, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    pos_q.delete();
  endtask

  // One clock cycle: drive, check at negedge, advance model at posedge.
  task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy,
                      input logic rst_v, input logic fl);
    logic         e_ir, e_ov, acc, cons;
    logic [W-1:0] e_od;
    int           sz, lim, np;
    rst_n = rst_v; in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    @(negedge clk);
    sz = exp_q.size();
    if (dep == 0) begin
      e_ov = iv && !fl;
      e_ir = ordy && !fl;
      e_od = id;
    end else begin
      e_ir = ((sz < dep) || ordy) && !fl;
      e_ov = (sz > 0) && (pos_q[0] == dep - 1) && !fl;
      e_od = last_od;
    end
    if (chk_en) begin
      chk("in_ready",  32'(ir),  32'(e_ir));
      chk("out_valid", 32'(ov),  32'(e_ov));
      chk("out_data",  32'(od),  32'(e_od));
      chk("occupancy", 32'(occ), (dep == 0) ? 32'd0 : 32'(sz));
    end
    acc  = iv && e_ir && rst_v;
    cons = e_ov && ordy && rst_v;
    @(posedge clk);
    if (!rst_v) begin
      model_clear();
      last_od = '0;
    end else if (fl) begin
      model_clear();
    end else begin
      if (acc && first_acc < 0) first_acc = cyc;
      if (cons) begin
        out_cnt++;
        if (first_out < 0) first_out = cyc;
      end
      if (dep > 0) begin
        if (cons) begin
          exp_q.pop_front();
          pos_q.pop_front();
        end
        lim = dep - 1;
        for (int i = 0; i < pos_q.size(); i++) begin
          np = pos_q[i] + 1;
          if (np > lim) np = lim;
          if (np == dep - 1 && pos_q[i] != dep - 1) last_od = exp_q[i];
          pos_q[i] = np;
          lim = np - 1;
        end
        if (acc) begin
          exp_q.push_back(id);
          pos_q.push_back(0);
          if (dep == 1) last_od = id;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, '0, ordy, 1'b1, 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    last_od = '0;
    cyc = 0; out_cnt = 0; first_acc = -1; first_out = -1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      cur = k;
      dep = DEPS[k];
      model_clear();
      last_od = '0;

      // Reset held 3 cycles with a beat offered: nothing may be taken.
      step(1'b1, 15'h7FFF, 1'b1, 1'b0, 1'b0);
      chk_en = 1'b1;
      step(1'b1, 15'h7FFF, 1'b1, 1'b0, 1'b0);
      step(1'b1, 15'h7FFF, 1'b1, 1'b0, 1'b0);
      chk("rst_occupancy", 32'(occ), 32'd0);
      idle(dep + 2, 1'b1);

      // Streaming 1..100 back-to-back.
      out_cnt = 0; first_acc = -1; first_out = -1;
      for (int v = 1; v <= 100; v++) step(1'b1, W'(v), 1'b1, 1'b1, 1'b0);
      idle(dep + 2, 1'b1);
      chk("stream_count",   32'(out_cnt), 32'd100);
      chk("stream_latency", 32'(first_out - first_acc), 32'(dep));

      // Back-pressure.
      step(1'b1, 15'h0AAA, 1'b0, 1'b1, 1'b0);
      step(1'b1, 15'h0BBB, 1'b0, 1'b1, 1'b0);
      step(1'b1, 15'h0CCC, 1'b0, 1'b1, 1'b0);
      idle(4, 1'b0);
      idle(dep + 4, 1'b1);

      // Bubble collapse: lone beat travels to the end, then the rest fill.
      step(1'b1, 15'h1234, 1'b0, 1'b1, 1'b0);
      idle(5, 1'b0);
      chk("bubble_head", 32'(ov), 32'(dep > 0));
      for (int i = 0; i < 6; i++) step(1'b1, W'(16'h2000 + i), 1'b0, 1'b1, 1'b0);
      chk("bubble_fill", 32'(occ), 32'(dep));

      // Full with simultaneous push and pop.
      for (int i = 0; i < 20; i++) step(1'b1, W'(16'h3000 + i), 1'b1, 1'b1, 1'b0);
      chk("full_occupancy", 32'(occ), 32'(dep));
      idle(dep + 2, 1'b1);

      // Mid-stream reset.
      for (int i = 0; i < 3; i++) step(1'b1, W'(16'h4000 + i), 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("midrst_occupancy", 32'(occ), 32'd0);
      idle(dep + 3, 1'b1);

`ifdef PIPELINE_ELASTIC_FLUSH_EN
      // Same again using flush.
      for (int i = 0; i < 3; i++) step(1'b1, W'(16'h5000 + i), 1'b0, 1'b1, 1'b0);
      step(1'b1, 15'h5555, 1'b1, 1'b1, 1'b1);
      chk("flush_occupancy", 32'(occ), 32'd0);
      idle(dep + 3, 1'b1);
`endif

      // Random traffic with occasional reset.
      for (int i = 0; i < 300; i++) begin
        step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 63) != 0), 1'b0);
      end
      idle(dep + 2, 1'b1);
      chk("drain_occupancy", 32'(occ), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
